// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU command, control and digit-level argument types
package alu_pkg;
  localparam int ALU_DW = 4;
  typedef enum logic [1:0] {ADD, SUB, RSHFT, LSHFT} AluCmd;
  typedef struct packed {
    logic  carry_in;
    logic  b_inv;
    logic  carry_disable;
    AluCmd cmd;
  } AluCtrl;
  typedef struct packed {
    AluCtrl            ctrl;
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
  } AluArgs;
  typedef struct packed {
    logic [ALU_DW-1:0] y;
    logic              co;
  } AluRet;
endpackage

// File: rtl/digit_serial_alu_seq_if.sv
// digit_serial_alu_seq_if: request/result bundle between decode and the digit-serial sequencer
interface digit_serial_alu_seq_if import alu_pkg::*; #(parameter int WORD_W = 32, parameter int DIGIT_W = 4);
  localparam int NDIG = WORD_W / DIGIT_W;
  localparam int LW = $clog2(NDIG);
  logic              start;
  AluCmd             cmd;
  logic [LW-1:0]     len;
  logic              w2_neg;
  logic [WORD_W-1:0] word1;
  logic [WORD_W-1:0] word2;
  logic [WORD_W-1:0] preinit;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] result;
  logic              carry_out;
  modport master(output start, cmd, len, w2_neg, word1, word2, preinit, input busy, done, result, carry_out);
  modport slave(input start, cmd, len, w2_neg, word1, word2, preinit, output busy, done, result, carry_out);
endinterface

// File: rtl/digit_serial_alu_seq_digit_alu.sv
// digit_alu: one-digit adder with optional operand inversion and carry-in gating
module digit_alu import alu_pkg::*; #(parameter int DIGIT_W = 4) (
  input  AluCtrl             ctrl,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [DIGIT_W-1:0] y,
  output logic               co
);
  logic               inv;
  logic [DIGIT_W-1:0] bb;
  logic [DIGIT_W:0]   sum;
  always_comb begin
    inv = ctrl.b_inv || ctrl.cmd == SUB;
    bb  = inv ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{DIGIT_W{1'b0}}, ctrl.carry_in & ~ctrl.carry_disable};
  end
  assign {co, y} = sum;
endmodule

// File: rtl/digit_serial_alu_seq.sv
// digit_serial_alu_seq: walks one DIGIT_W-bit ALU across a WORD_W-bit operand pair, one digit per clock
// Optional DSEQ_EARLY_EXIT_EN: ADD/SUB stop as soon as the carry chain settles above len.
module digit_serial_alu_seq import alu_pkg::*; #(parameter int WORD_W = 32, parameter int DIGIT_W = 4) (
  input logic                   clk,
  input logic                   rst_n,
  digit_serial_alu_seq_if.slave bus
);
  localparam int NDIG = WORD_W / DIGIT_W;
  localparam int LW = $clog2(NDIG);
  localparam logic [LW:0] CMAX = (LW+1)'(NDIG - 1);
  localparam logic [LW:0] ONE = (LW+1)'(1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state, state_d;
  AluCmd              cmd_q;
  logic [LW-1:0]      len_q, i;
  logic               w2_neg_q, c_q, co_q, c_sum, c_nxt, last, stop_arith;
  logic [WORD_W-1:0]  w1_q, w2_q, res_q;
  logic [LW:0]        cnt;
  logic [DIGIT_W-1:0] d1, d2, sum, dig;
  AluCtrl             ctrl;
  assign i    = cnt[LW-1:0];
  assign d1   = w1_q[i*DIGIT_W +: DIGIT_W];
  assign d2   = i > len_q ? {DIGIT_W{w2_neg_q}} : w2_q[i*DIGIT_W +: DIGIT_W];
  assign ctrl = '{carry_in: c_q, b_inv: cmd_q == SUB, carry_disable: 1'b0, cmd: cmd_q};
  digit_alu #(.DIGIT_W(DIGIT_W)) u_alu (.ctrl(ctrl), .a(d1), .b(d2), .y(sum), .co(c_sum));
  assign dig   = cmd_q == RSHFT ? {c_q, d2[DIGIT_W-1:1]} : cmd_q == LSHFT ? {d2[DIGIT_W-2:0], c_q} : sum;
  assign c_nxt = cmd_q == RSHFT ? d2[0] : cmd_q == LSHFT ? d2[DIGIT_W-1] : c_sum;
`ifdef DSEQ_EARLY_EXIT_EN
  // SUB's carry is NOT borrow, so a set carry means the chain has settled
  assign stop_arith = i >= len_q && !w2_neg_q && (c_sum == (cmd_q == SUB));
`else
  assign stop_arith = 1'b0;
`endif
  assign last = cmd_q == RSHFT ? i == '0 : cmd_q == LSHFT ? i == len_q : (stop_arith || cnt == CMAX);
  always_comb begin
    state_d = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q    <= '0;
      c_q      <= 1'b0;
      co_q     <= 1'b0;
      cnt      <= '0;
      cmd_q    <= ADD;
      len_q    <= '0;
      w2_neg_q <= 1'b0;
      w1_q     <= '0;
      w2_q     <= '0;
    end else if (state == IDLE && bus.start) begin
      cmd_q    <= bus.cmd;
      len_q    <= bus.len;
      w2_neg_q <= bus.w2_neg;
      w1_q     <= bus.word1;
      w2_q     <= bus.word2;
      res_q    <= bus.preinit;
      c_q      <= bus.cmd == SUB;
      cnt      <= bus.cmd == RSHFT ? {1'b0, bus.len} : '0;
    end else if (state == RUN) begin
      res_q[i*DIGIT_W +: DIGIT_W] <= dig;
      c_q <= c_nxt;
      cnt <= cmd_q == RSHFT ? cnt - ONE : cnt + ONE;
      if (last) co_q <= c_nxt;
    end
  end
  assign bus.busy      = state == RUN;
  assign bus.done      = state == DONE;
  assign bus.result    = res_q;
  assign bus.carry_out = co_q;
endmodule
